// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@60, 40 MHz pixel clock) and the
// 11-bit count type used by the timing generator and the drawing stages.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;

  localparam int PIXEL_CLK_HZ = 40_000_000;

  function automatic cnt_t wrap_inc(input cnt_t cur, input cnt_t last);
    return (cur == last) ? '0 : cur + cnt_t'(1);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing-generator output bundle; frame_cnt exists only when
// VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
  import vga_pkg::*;

  logic en;
  cnt_t hcount_out;
  logic hsync_out;
  logic hblnk_out;
  cnt_t vcount_out;
  logic vsync_out;
  logic vblnk_out;
  logic frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  en,
    output hcount_out, hsync_out, hblnk_out,
    output vcount_out, vsync_out, vblnk_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output frame_cnt,
`endif
    output frame_start
  );

  modport slave (
    output en,
    input  hcount_out, hsync_out, hblnk_out,
    input  vcount_out, vsync_out, vblnk_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with registered blank/sync decode.
// wrap is a same-cycle strobe used to step the next axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output cnt_t count,
  output logic blnk,
  output logic sync,
  output logic wrap
);

  localparam cnt_t LAST    = cnt_t'(ACTIVE + FP + SYNC + BP - 1);
  localparam cnt_t ACT     = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_LO = cnt_t'(ACTIVE + FP);
  localparam cnt_t SYNC_HI = cnt_t'(ACTIVE + FP + SYNC - 1);

  cnt_t next;

  assign wrap = step && (count == LAST);
  assign next = wrap_inc(count, LAST);

  // Flags are decoded from the value being loaded so they line up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= 1'b0;
    end else if (step) begin
      count <= next;
      blnk  <= (next >= ACT);
      sync  <= (next >= SYNC_LO) && (next <= SYNC_HI);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal axis stepped by en, vertical axis
// stepped by the horizontal wrap. Define VGA_TIMING_FRAME_CNT_EN for frame_cnt.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master vga
);

  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk  (clk),
    .rst  (rst),
    .step (vga.en),
    .count(vga.hcount_out),
    .blnk (vga.hblnk_out),
    .sync (vga.hsync_out),
    .wrap (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk  (clk),
    .rst  (rst),
    .step (h_wrap),
    .count(vga.vcount_out),
    .blnk (vga.vblnk_out),
    .sync (vga.vsync_out),
    .wrap (v_wrap)
  );

  // v_wrap already implies the horizontal wrap, i.e. the (last,last) advance.
  always_ff @(posedge clk) begin
    if (rst) vga.frame_start <= 1'b0;
    else     vga.frame_start <= v_wrap;
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         vga.frame_cnt <= '0;
    else if (v_wrap) vga.frame_cnt <= vga.frame_cnt + 16'd1;
  end
`endif

endmodule
